xgmii_tx_fifo_arbiter: RTL and testbench
========================================

Name: xgmii_tx_fifo_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the single 72-bit XGMII-TX FIFO write port between two snoop sources: port 0 is PCIe RX snoop, port 1 is PCIe TX snoop.
- Forwards whole packets only and never interleaves words of two packets.
- Inserts a fixed run of idle words after every packet, so sources no longer generate gaps themselves.
- Sits between the snoop blocks and the FIFO feeding the XGMII framer.

Parameters:
- GAP_WORDS, 3'd7, number of idle words (din = 72'h0) written after each packet's last word; 0 disables gap insertion.
- MAX_WORDS, 10'd600, watchdog limit on words per packet; reaching it force-terminates the packet.

Ports:
- clk  in  1  core clock
- sys_rst_n  in  1  asynchronous active-low reset
- s0_data  in  72  port 0 word, {tkeep[7:0], tdata[63:0]}
- s0_valid  in  1  port 0 word valid
- s0_last  in  1  port 0 final word of packet
- s0_ready  out  1  port 0 word accepted this cycle
- s1_data, s1_valid, s1_last, s1_ready  as port 0, for port 1
- din  out  72  FIFO write data
- wr_en  out  1  FIFO write strobe
- full  in  1  FIFO prog-full; asserted with at least 2 free entries remaining
- trunc_err  out  1  one-cycle pulse when the watchdog terminates a packet

Behaviour:
- Reset (async, sys_rst_n low): state=IDLE, din=72'h0, wr_en=0, s0_ready=s1_ready=0, trunc_err=0, last_grant=1 (so port 0 wins first), word and gap counters=0.
- s*_ready is combinational:
  - ready = (state==PASS) && (grant==port) && !full.
  - A word transfers when valid && ready.
- din and wr_en are registered:
  - Transferred word appears on din with wr_en=1 one cycle after transfer.
  - Each transfer produces exactly one write.
- IDLE:
  - If neither valid is set, stay.
  - If one is valid, grant it.
  - If both are valid, grant the port != last_grant.
  - Grant takes effect next cycle: IDLE -> PASS.
  - No word is accepted in IDLE, so the minimum gap between packets is 1 cycle plus gap words.
- PASS:
  - Only the granted port may be ready; the other port's ready stays 0 regardless of its valid.
  - On a transfer with last=1:
    - last_grant <= grant.
    - If GAP_WORDS>0: gap counter <= GAP_WORDS, go to GAP.
    - Otherwise go to IDLE.
  - Word counter increments per transfer and clears on packet start.
  - Watchdog: on a transfer that is the MAX_WORDS-th word with last=0:
    - Write that word with tkeep forced to 8'hFF.
    - Pulse trunc_err.
    - Go to GAP or IDLE as for last=1.
    - Remaining source words are then treated as a new packet at next grant. This is accepted behaviour.
- GAP:
  - Each cycle with !full: write din=72'h0, wr_en=1, decrement the counter.
  - When the counter reaches 0 after the final write, go to IDLE.
  - While full=1: no write, counter holds.
- full in PASS or GAP stalls all writes; no word is dropped or duplicated.
- Valid may drop mid-packet (bubble): the arbiter holds the grant and waits; wr_en=0 for that cycle.
- A source must not change data while valid && !ready; the arbiter does not check this.
- Fairness: with both ports continuously valid, packets alternate 0,1,0,1.
- Single-word packet (valid && last on first word) is legal: 1 data write followed by the gap.

Optional Feature:
- ARB_STATS_EN defined: adds outputs pkt_cnt0[31:0], pkt_cnt1[31:0], trunc_cnt[15:0].
  - Each counter increments on packet completion or truncation for its port, wraps at all-ones, and resets to 0.
- ARB_STATS_EN undefined: these ports and their registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Single packet, port 0 only, 3 words A,B,C with last on C, GAP_WORDS=7, full=0 -> wr_en high 10 consecutive cycles: A,B,C then seven 72'h0; s1_ready stays 0.
- Both ports valid from reset, each sending 2-word packets continuously -> grant order 0,1,0,1; each data word written once; 7 zero words between every packet.
- full=1 asserted for 4 cycles in the middle of a 5-word packet -> ready and wr_en low those 4 cycles; all 5 words written in order; total write count = 5+7.
- full=1 during GAP after 3 zero words -> gap pauses; exactly 4 more zero words after full drops (7 total).
- MAX_WORDS=4, port 1 sends 6 words with last on word 6 -> word 4 written with tkeep=8'hFF and trunc_err pulses once; gap follows. With ARB_STATS_EN, trunc_cnt=1.
- Reset asserted mid-packet on word 2 of port 0 -> asynchronously wr_en=0 and din=0; after release, port 0 is granted first and a new packet is forwarded cleanly.

Source files
------------

// File: rtl/xgmii_tx_fifo_arbiter.sv
// xgmii_tx_fifo_arbiter
// Packet-granular round-robin arbiter that shares the single 72-bit XGMII-TX
// FIFO write port between two snoop sources (port 0: PCIe RX snoop, port 1:
// PCIe TX snoop). Only whole packets are forwarded, a fixed run of idle words
// follows every packet, and a per-packet word watchdog force-terminates
// runaway packets.
// Build option: define ARB_STATS_EN to add per-port packet counters and a
// truncation counter.
module xgmii_tx_fifo_arbiter #(
  parameter logic [2:0] GAP_WORDS = 3'd7,    // idle words after each packet, 0 = none
  parameter logic [9:0] MAX_WORDS = 10'd600  // watchdog limit on words per packet
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  // port 0: {tkeep[7:0], tdata[63:0]}
  input  logic [71:0] s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  // port 1: {tkeep[7:0], tdata[63:0]}
  input  logic [71:0] s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  // FIFO write side
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic        trunc_err
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1,
  output logic [15:0] trunc_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a source, picks the next grant
    PASS = 2'd1,  // forwarding the granted source's packet
    GAP  = 2'd2   // writing idle words after a packet
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;          // port currently owning the write port
  logic        last_grant_q, last_grant_d; // port that finished the previous packet
  logic [9:0]  word_cnt_q, word_cnt_d;    // words transferred in the current packet
  logic [2:0]  gap_cnt_q, gap_cnt_d;      // idle words still to write
  logic [71:0] din_d;
  logic        wr_en_d;
  logic        trunc_d;

  logic [71:0] sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic        xfer;      // a source word moves this cycle
  logic        wd_hit;    // this transfer reaches the watchdog limit without last
  logic        pkt_end;   // this transfer closes the packet (last or watchdog)

  // Granted source view; only the granted port can ever be ready.
  assign sel_data  = grant_q ? s1_data  : s0_data;
  assign sel_valid = grant_q ? s1_valid : s0_valid;
  assign sel_last  = grant_q ? s1_last  : s0_last;

  assign s0_ready = (state_q == PASS) && !grant_q && !full;
  assign s1_ready = (state_q == PASS) &&  grant_q && !full;

  assign xfer    = sel_valid && (state_q == PASS) && !full;
  assign wd_hit  = xfer && !sel_last && (word_cnt_q == MAX_WORDS - 10'd1);
  assign pkt_end = xfer && (sel_last || wd_hit);

  // Next-state, grant selection and the registered write-port values.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    din_d        = 72'h0;
    wr_en_d      = 1'b0;
    trunc_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          state_d    = PASS;
          word_cnt_d = 10'd0;
          if (s0_valid && s1_valid) begin
            grant_d = ~last_grant_q;  // round-robin when both compete
          end else begin
            grant_d = s1_valid;
          end
        end
      end

      PASS: begin
        if (xfer) begin
          wr_en_d    = 1'b1;
          // A truncated word is written as a full-width word.
          din_d      = wd_hit ? {8'hFF, sel_data[63:0]} : sel_data;
          word_cnt_d = word_cnt_q + 10'd1;
        end
        if (pkt_end) begin
          last_grant_d = grant_q;
          trunc_d      = wd_hit;
          if (GAP_WORDS != 3'd0) begin
            gap_cnt_d = GAP_WORDS;
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        // Idle words respect back-pressure too; the counter holds while full.
        if (!full) begin
          wr_en_d   = 1'b1;
          gap_cnt_d = gap_cnt_q - 3'd1;
          if (gap_cnt_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and counter registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first contest
      word_cnt_q   <= 10'd0;
      gap_cnt_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Registered FIFO write port and truncation pulse.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      din       <= 72'h0;
      wr_en     <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      din       <= din_d;
      wr_en     <= wr_en_d;
      trunc_err <= trunc_d;
    end
  end

`ifdef ARB_STATS_EN
  // Per-port packet counters (completed or truncated) and truncation counter;
  // all wrap naturally at all-ones.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_cnt0  <= 32'd0;
      pkt_cnt1  <= 32'd0;
      trunc_cnt <= 16'd0;
    end else begin
      if (pkt_end) begin
        if (grant_q) begin
          pkt_cnt1 <= pkt_cnt1 + 32'd1;
        end else begin
          pkt_cnt0 <= pkt_cnt0 + 32'd1;
        end
      end
      if (wd_hit) begin
        trunc_cnt <= trunc_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_tx_fifo_arbiter.sv
// tb_xgmii_tx_fifo_arbiter
// Directed bench for xgmii_tx_fifo_arbiter. Instance dut uses the default
// parameters; instance dut_wd uses MAX_WORDS=4 for the watchdog scenario.
// Honours ARB_STATS_EN when defined.
module tb_xgmii_tx_fifo_arbiter;

  logic clk = 1'b0;
  logic sys_rst_n;
  always #5 clk = ~clk;

  // main instance
  logic [71:0] s0_data, s1_data, din;
  logic        s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic        wr_en, full, trunc_err;
  // watchdog instance
  logic [71:0] w0_data, w1_data, wd_din;
  logic        w0_valid, w0_last, w0_ready, w1_valid, w1_last, w1_ready;
  logic        wd_wr_en, wd_full, wd_trunc_err;
`ifdef ARB_STATS_EN
  logic [31:0] m_pkt_cnt0, m_pkt_cnt1, wd_pkt_cnt0, wd_pkt_cnt1;
  logic [15:0] m_trunc_cnt, wd_trunc_cnt;
`endif

  xgmii_tx_fifo_arbiter dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .din(din), .wr_en(wr_en), .full(full), .trunc_err(trunc_err)
`ifdef ARB_STATS_EN
    , .pkt_cnt0(m_pkt_cnt0), .pkt_cnt1(m_pkt_cnt1), .trunc_cnt(m_trunc_cnt)
`endif
  );

  xgmii_tx_fifo_arbiter #(.GAP_WORDS(3'd7), .MAX_WORDS(10'd4)) dut_wd (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .s0_data(w0_data), .s0_valid(w0_valid), .s0_last(w0_last), .s0_ready(w0_ready),
    .s1_data(w1_data), .s1_valid(w1_valid), .s1_last(w1_last), .s1_ready(w1_ready),
    .din(wd_din), .wr_en(wd_wr_en), .full(wd_full), .trunc_err(wd_trunc_err)
`ifdef ARB_STATS_EN
    , .pkt_cnt0(wd_pkt_cnt0), .pkt_cnt1(wd_pkt_cnt1), .trunc_cnt(wd_trunc_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write log per instance, captured on the falling edge.
  int          cyc = 0;
  logic [71:0] wdata0[$];
  int          wcyc0[$];
  logic [71:0] wdata1[$];
  logic [71:0] exp_q[$];
  int          trunc0 = 0;
  int          trunc1 = 0;
  bit          s1_rdy_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      wdata0.push_back(din);
      wcyc0.push_back(cyc);
    end
    if (wd_wr_en) wdata1.push_back(wd_din);
    if (trunc_err) trunc0++;
    if (wd_trunc_err) trunc1++;
    if (s1_ready) s1_rdy_seen = 1'b1;
  end

  // Source word: tkeep 8'h3F on inner words, 8'h0F on the last word.
  function automatic logic [71:0] mk(int p, int tag, int idx, bit last);
    logic [63:0] d;
    d = {16'hDA00 + 16'(p), 16'(tag), 16'(idx), 16'hBEEF};
    return {(last ? 8'h0F : 8'h3F), d};
  endfunction

  function automatic void exp_pkt(int p, int tag, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(p, tag, i, i == n - 1));
  endfunction

  function automatic void exp_gap();
    for (int i = 0; i < 7; i++) exp_q.push_back(72'h0);
  endfunction

  function automatic int zeros0();
    int z = 0;
    foreach (wdata0[i]) if (wdata0[i] == 72'h0) z++;
    return z;
  endfunction

  task automatic clear_logs();
    wdata0.delete();
    wcyc0.delete();
    wdata1.delete();
    exp_q.delete();
    trunc0 = 0;
    trunc1 = 0;
    s1_rdy_seen = 1'b0;
  endtask

  task automatic set_src(input int d, input int p, input logic v, input logic [71:0] dat,
                         input logic l);
    if (d == 0 && p == 0) begin s0_valid = v; s0_data = dat; s0_last = l; end
    else if (d == 0)      begin s1_valid = v; s1_data = dat; s1_last = l; end
    else if (p == 0)      begin w0_valid = v; w0_data = dat; w0_last = l; end
    else                  begin w1_valid = v; w1_data = dat; w1_last = l; end
  endtask

  function automatic logic rdy(int d, int p);
    if (d == 0) return (p == 0) ? s0_ready : s1_ready;
    return (p == 0) ? w0_ready : w1_ready;
  endfunction

  // Offers one packet word by word; entered and left at posedge+1.
  task automatic send_pkt(input int d, input int p, input int tag, input int n);
    int i = 0;
    int guard = 0;
    while (i < n) begin
      set_src(d, p, 1'b1, mk(p, tag, i, i == n - 1), i == n - 1);
      @(negedge clk);
      if (rdy(d, p)) i++;
      @(posedge clk); #1;
      guard++;
      if (guard > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: dut %0d port %0d got %0d words want %0d", d, p, i, n);
        break;
      end
    end
    set_src(d, p, 1'b0, 72'h0, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #3;
    @(negedge clk) sys_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1; w0_valid = 1'b1; w1_valid = 1'b1;
    #6;
    n_cmp++; if (din !== 72'h0) begin n_bad++; $display("FAIL rst_din: got %h want 0", din); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_ready: got %b%b want 00", s0_ready, s1_ready); end
    n_cmp++; if (trunc_err !== 1'b0) begin n_bad++; $display("FAIL rst_trunc: got %b want 0", trunc_err); end
    n_cmp++; if (wd_din !== 72'h0 || wd_wr_en !== 1'b0 || wd_trunc_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_wd_out: got %h/%b/%b want 0/0/0", wd_din, wd_wr_en, wd_trunc_err); end
    n_cmp++; if (w0_ready !== 1'b0 || w1_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_wd_ready: got %b%b want 00", w0_ready, w1_ready); end
`ifdef ARB_STATS_EN
    n_cmp++; if (m_pkt_cnt0 !== 32'd0 || m_pkt_cnt1 !== 32'd0 || m_trunc_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", m_pkt_cnt0, m_pkt_cnt1, m_trunc_cnt); end
`endif
    s0_valid = 1'b0; s1_valid = 1'b0; w0_valid = 1'b0; w1_valid = 1'b0;
    @(negedge clk) sys_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Port 0 alone, 3 words: A,B,C then seven zero words on 10 consecutive cycles.
  task automatic test_single_packet();
    bit consec = 1'b1;
    clear_logs();
    send_pkt(0, 0, 10, 3);
    repeat (10) @(posedge clk); #1;
    exp_pkt(0, 10, 3); exp_gap();
    n_cmp++; if (wdata0.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t1_len: got %0d want %0d", wdata0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t1_word[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end
    for (int i = 1; i < wcyc0.size(); i++) if (wcyc0[i] != wcyc0[0] + i) consec = 1'b0;
    n_cmp++; if (consec !== 1'b1) begin n_bad++; $display("FAIL t1_consecutive: got 0 want 1"); end
    n_cmp++; if (s1_rdy_seen !== 1'b0) begin n_bad++; $display("FAIL t1_s1_ready: got 1 want 0"); end
  endtask

  // Both ports valid straight out of reset: packets alternate 0,1,0,1.
  task automatic test_round_robin();
    do_reset();
    clear_logs();
    fork
      begin send_pkt(0, 0, 20, 2); send_pkt(0, 0, 21, 2); end
      begin send_pkt(0, 1, 22, 2); send_pkt(0, 1, 23, 2); end
    join
    repeat (12) @(posedge clk); #1;
    exp_pkt(0, 20, 2); exp_gap(); exp_pkt(1, 22, 2); exp_gap();
    exp_pkt(0, 21, 2); exp_gap(); exp_pkt(1, 23, 2); exp_gap();
    n_cmp++; if (wdata0.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t2_len: got %0d want %0d", wdata0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t2_word[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end
    n_cmp++; if (trunc0 !== 0) begin n_bad++; $display("FAIL t2_trunc: got %0d want 0", trunc0); end
  endtask

  // full for 4 cycles after two words of a 5-word packet.
  task automatic test_full_stall();
    int rdy_hi = 0;
    int wr_hi = 0;
    clear_logs();
    fork
      send_pkt(0, 0, 30, 5);
      begin
        repeat (3) @(posedge clk); #1 full = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (s0_ready) rdy_hi++;
          if (k > 0 && wr_en) wr_hi++;
          @(posedge clk); #1;
        end
        full = 1'b0;
        @(negedge clk);
        if (wr_en) wr_hi++;
        @(posedge clk); #1;
      end
    join
    repeat (12) @(posedge clk); #1;
    exp_pkt(0, 30, 5); exp_gap();
    n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL t3_ready_in_full: got %0d want 0", rdy_hi); end
    n_cmp++; if (wr_hi !== 0) begin n_bad++; $display("FAIL t3_wr_in_full: got %0d want 0", wr_hi); end
    n_cmp++; if (wdata0.size() !== 12) begin
      n_bad++; $display("FAIL t3_len: got %0d want 12", wdata0.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t3_word[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end
  endtask

  // full during the gap after 3 zero words: gap pauses, then 4 more zeros.
  task automatic test_gap_pause();
    int z_pause = 0;
    int z_hold = 0;
    clear_logs();
    fork
      send_pkt(0, 1, 40, 2);
      begin
        repeat (6) @(posedge clk); #1 full = 1'b1;
        repeat (3) @(posedge clk); #1 full = 1'b0;
        z_pause = zeros0();
        @(posedge clk); #1;
        z_hold = zeros0();
      end
    join
    repeat (10) @(posedge clk); #1;
    exp_pkt(1, 40, 2); exp_gap();
    n_cmp++; if (z_pause !== 3) begin n_bad++; $display("FAIL t4_zeros_before: got %0d want 3", z_pause); end
    n_cmp++; if (z_hold !== 3) begin n_bad++; $display("FAIL t4_zeros_held: got %0d want 3", z_hold); end
    n_cmp++; if (zeros0() - z_pause !== 4) begin
      n_bad++; $display("FAIL t4_zeros_after: got %0d want 4", zeros0() - z_pause); end
    n_cmp++; if (wdata0.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t4_len: got %0d want %0d", wdata0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t4_word[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end
  endtask

  // MAX_WORDS=4, port 1 offers 6 words: word 4 forced to tkeep FF, then gap,
  // remaining 2 words form a new packet.
  task automatic test_watchdog();
    logic [71:0] w;
    clear_logs();
    send_pkt(1, 1, 50, 6);
    repeat (12) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 50, i, 1'b0));
    w = mk(1, 50, 3, 1'b0);
    w[71:64] = 8'hFF;
    exp_q.push_back(w);
    exp_gap();
    exp_q.push_back(mk(1, 50, 4, 1'b0));
    exp_q.push_back(mk(1, 50, 5, 1'b1));
    exp_gap();
    n_cmp++; if (trunc1 !== 1) begin n_bad++; $display("FAIL t5_trunc_pulses: got %0d want 1", trunc1); end
    n_cmp++; if (wdata1.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t5_len: got %0d want %0d", wdata1.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata1.size(); i++) begin
      n_cmp++; if (wdata1[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t5_word[%0d]: got %h want %h", i, wdata1[i], exp_q[i]); end
    end
`ifdef ARB_STATS_EN
    n_cmp++; if (wd_trunc_cnt !== 16'd1) begin
      n_bad++; $display("FAIL t5_trunc_cnt: got %0d want 1", wd_trunc_cnt); end
    n_cmp++; if (wd_pkt_cnt1 !== 32'd2 || wd_pkt_cnt0 !== 32'd0) begin
      n_bad++; $display("FAIL t5_pkt_cnt: got %0d/%0d want 0/2", wd_pkt_cnt0, wd_pkt_cnt1); end
`endif
  endtask

  // Single-word packet on port 0, then reset during word 2 of the next port 0
  // packet; after release port 0 still wins against port 1.
  task automatic test_reset_mid_packet();
    clear_logs();
    send_pkt(0, 0, 60, 1);
    repeat (10) @(posedge clk); #1;
    exp_pkt(0, 60, 1); exp_gap();
    n_cmp++; if (wdata0.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t6_single_len: got %0d want %0d", wdata0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t6_single[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end

    clear_logs();
    set_src(0, 0, 1'b1, mk(0, 61, 0, 1'b0), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_src(0, 0, 1'b1, mk(0, 61, 1, 1'b0), 1'b0);
    @(posedge clk); #1;
    set_src(0, 0, 1'b1, mk(0, 61, 2, 1'b0), 1'b0);
    n_cmp++; if (wr_en !== 1'b1 || din !== mk(0, 61, 1, 1'b0)) begin
      n_bad++; $display("FAIL t6_word2: got %b/%h want 1/%h", wr_en, din, mk(0, 61, 1, 1'b0)); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0 || din !== 72'h0) begin
      n_bad++; $display("FAIL t6_async_rst: got %b/%h want 0/0", wr_en, din); end
    n_cmp++; if (s0_ready !== 1'b0) begin n_bad++; $display("FAIL t6_rst_ready: got %b want 0", s0_ready); end
    set_src(0, 0, 1'b0, 72'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) sys_rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    fork
      send_pkt(0, 0, 62, 2);
      send_pkt(0, 1, 63, 2);
    join
    repeat (12) @(posedge clk); #1;
    exp_pkt(0, 62, 2); exp_gap(); exp_pkt(1, 63, 2); exp_gap();
    n_cmp++; if (wdata0.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t6_len: got %0d want %0d", wdata0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wdata0.size(); i++) begin
      n_cmp++; if (wdata0[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t6_word[%0d]: got %h want %h", i, wdata0[i], exp_q[i]); end
    end
  endtask

  initial begin
    s0_data = '0; s0_valid = 1'b0; s0_last = 1'b0;
    s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0;
    w0_data = '0; w0_valid = 1'b0; w0_last = 1'b0;
    w1_data = '0; w1_valid = 1'b0; w1_last = 1'b0;
    full = 1'b0; wd_full = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_gap_pause();
    test_watchdog();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
